// File: rtl/dram_bram_responder.sv
// BRAM-backed stand-in for the DDR3 controller user interface with cycle-exact init, busy and read latency.
// Optional periodic refresh emulation is enabled by defining DRAM_RESPONDER_REFRESH_EN.
module dram_bram_responder #(
  parameter int unsigned ADDR_BITS        = 10,
  parameter int unsigned INIT_CYCLES      = 16,
  parameter int unsigned BUSY_CYCLES      = 2,
  parameter int unsigned READ_LATENCY     = 4,
  parameter int unsigned REFRESH_INTERVAL = 64,
  parameter int unsigned REFRESH_CYCLES   = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic         sdram_init_busy,
  input  logic [26:0]  dram_address,
  input  logic         dram_write,
  input  logic         dram_valid,
  output logic         dram_ready,
  input  logic [127:0] dram_wdata,
  input  logic [15:0]  dram_wdata_mask,
  output logic [127:0] dram_rdata,
  output logic         dram_rdata_valid
);

  localparam int unsigned LINES    = 1 << ADDR_BITS;
  localparam int unsigned BYTES    = 16;
  localparam int unsigned MAX_IB   = (INIT_CYCLES > BUSY_CYCLES) ? INIT_CYCLES : BUSY_CYCLES;
  localparam int unsigned MAX_IBR  = (MAX_IB > READ_LATENCY) ? MAX_IB : READ_LATENCY;
  localparam int unsigned MAX_RF   = (REFRESH_INTERVAL > REFRESH_CYCLES) ? REFRESH_INTERVAL : REFRESH_CYCLES;
  localparam int unsigned MAX_ALL  = (MAX_IBR > MAX_RF) ? MAX_IBR : MAX_RF;
  localparam int unsigned CW       = $clog2(MAX_ALL) + 1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_REFRESH
  } state_t;

  state_t                 state;
  state_t                 state_d;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_d;
  logic [ADDR_BITS-1:0]   idx;
  logic                   accept;
  logic                   rd_fire;
  logic                   refresh_pending;
  logic [127:0]           rd_hold;
  logic [127:0]           mem [LINES];
  logic                   unused_addr;

  assign idx         = dram_address[ADDR_BITS+2:3];
  assign unused_addr = ^{dram_address[2:0], dram_address[26:ADDR_BITS+3]};
  assign dram_ready  = (state == ST_IDLE) && !refresh_pending;
  assign accept      = dram_valid && dram_ready;

  // Next-state and phase counter; every phase ends on a terminal count.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_INIT: begin
        if (cnt == CW'(INIT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_IDLE: begin
        if (refresh_pending) begin
          // The cycle in which the refresh is seen already counts as its first cycle.
          if (REFRESH_CYCLES > 1) begin
            state_d = ST_REFRESH;
            cnt_d   = CW'(1);
          end
        end else if (accept) begin
          state_d = dram_write ? ST_WRITE : ST_READ;
          cnt_d   = '0;
        end
      end
      ST_WRITE: begin
        if (cnt == CW'(BUSY_CYCLES - 1)) begin
          state_d = refresh_pending ? ST_REFRESH : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_READ: begin
        if (cnt == CW'(READ_LATENCY - 1)) begin
          state_d = refresh_pending ? ST_REFRESH : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_REFRESH: begin
        if (cnt == CW'(REFRESH_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign rd_fire = (state_d == ST_READ) && (cnt_d == CW'(READ_LATENCY - 1));

  // State register and registered outputs; read data captured at acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= ST_INIT;
      cnt              <= '0;
      sdram_init_busy  <= 1'b1;
      dram_rdata_valid <= 1'b0;
      dram_rdata       <= '0;
      rd_hold          <= '0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      sdram_init_busy  <= (state_d == ST_INIT);
      dram_rdata_valid <= rd_fire;
      if (accept && !dram_write) begin
        rd_hold <= mem[idx];
      end
      if (rd_fire) begin
        dram_rdata <= (READ_LATENCY == 1) ? mem[idx] : rd_hold;
      end
    end
  end

  // Byte-masked line write; mask bit set means the byte is kept.
  always_ff @(posedge clk) begin
    if (reset_n && accept && dram_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!dram_wdata_mask[b]) begin
          mem[idx][8*b +: 8] <= dram_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef DRAM_RESPONDER_REFRESH_EN
  logic [CW-1:0] ref_cnt;
  logic          ref_flag;
  logic          ref_due;
  logic          refresh_start;

  assign ref_due         = (state != ST_INIT) && (ref_cnt == CW'(REFRESH_INTERVAL - 1));
  assign refresh_pending = ref_flag || ref_due;
  assign refresh_start   = refresh_pending &&
                           ((state == ST_IDLE) || ((state_d == ST_REFRESH) && (state != ST_REFRESH)));

  // Free-running interval counter; a pending request waits for the current command to finish.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ref_cnt  <= '0;
      ref_flag <= 1'b0;
    end else begin
      if (state != ST_INIT) begin
        ref_cnt <= ref_due ? '0 : ref_cnt + CW'(1);
      end
      ref_flag <= refresh_pending && !refresh_start;
    end
  end
`else
  assign refresh_pending = 1'b0;
`endif

endmodule
